// File: rtl/nv_jtag_pkg.sv
// rtl/nv_jtag_pkg.sv - shared types and helpers for the segmented JTAG data register
package nv_jtag_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_CAP  = 2'd1,
    CMD_SHF  = 2'd2,
    CMD_UPD  = 2'd3
  } tap_cmd_e;

  localparam int MAX_SEG = 32;

  // Wide enough to count one past a full chain and still saturate distinctly.
  function automatic int cnt_width(input int total_bits);
    return $clog2(total_bits + 1) + 1;
  endfunction

  function automatic int chain_len(input logic [MAX_SEG-1:0] mask, input int num_seg,
                                   input int seg_width);
    int l;
    l = 0;
    for (int k = 0; k < num_seg; k++) begin
      l += mask[k] ? seg_width : 1;
    end
    return l;
  endfunction

  function automatic tap_cmd_e tap_cmd(input logic sel, input logic cap, input logic shf,
                                       input logic upd);
    tap_cmd_e c;
    c = CMD_IDLE;
    if (sel) begin
      if (cap)      c = CMD_CAP;
      else if (shf) c = CMD_SHF;
      else if (upd) c = CMD_UPD;
    end
    return c;
  endfunction

endpackage

// File: rtl/nv_jtag_dr_chain_if.sv
// rtl/nv_jtag_dr_chain_if.sv - TAP-side bundle for the segmented data register
interface nv_jtag_dr_chain_if #(
  parameter int NUM_SEG   = 4,
  parameter int SEG_WIDTH = 16
);
  logic                           sel;
  logic                           captureDR;
  logic                           shiftDR;
  logic                           updateDR;
  logic [NUM_SEG-1:0]             seg_en;
  logic [NUM_SEG*SEG_WIDTH-1:0]   D;
  logic                           scanin;
  logic                           scanout;
  logic [NUM_SEG*SEG_WIDTH-1:0]   Q;
  logic                           update_err;

  modport master (
    output sel, captureDR, shiftDR, updateDR, seg_en, D, scanin,
    input  scanout, Q, update_err
  );

  modport slave (
    input  sel, captureDR, shiftDR, updateDR, seg_en, D, scanin,
    output scanout, Q, update_err
  );
endinterface

// File: rtl/nv_jtag_dr_seg.sv
// rtl/nv_jtag_dr_seg.sv - one chain segment: shift flops, bypass flop and shadow slice
module nv_jtag_dr_seg #(
  parameter int                   SEG_WIDTH   = 16,
  parameter logic [SEG_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 en,
  input  logic                 cap_en,
  input  logic                 cap,
  input  logic                 shf,
  input  logic                 upd,
  input  logic [SEG_WIDTH-1:0] d,
  input  logic                 si,
  output logic                 so,
  output logic [SEG_WIDTH-1:0] q
);

  logic [SEG_WIDTH-1:0] sh_q, sh_d;
  logic                 byp_q, byp_d;
  logic [SEG_WIDTH-1:0] q_q, q_d;

  always_comb begin
    sh_d  = sh_q;
    byp_d = byp_q;
    q_d   = q_q;
    if (cap) begin
      byp_d = 1'b0;
      if (cap_en) sh_d = d;
    end else if (shf) begin
      // A disabled segment keeps its data and passes the bit through its bypass flop.
      if (en) sh_d = {si, sh_q[SEG_WIDTH-1:1]};
      else    byp_d = si;
    end else if (upd && en) begin
      q_d = sh_q;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sh_q  <= '0;
      byp_q <= 1'b0;
      q_q   <= RESET_VALUE;
    end else begin
      sh_q  <= sh_d;
      byp_q <= byp_d;
      q_q   <= q_d;
    end
  end

  assign so = en ? sh_q[0] : byp_q;
  assign q  = q_q;

endmodule

// File: rtl/nv_jtag_dr_chain.sv
// rtl/nv_jtag_dr_chain.sv - multi-segment JTAG data register with bypass and length check
module nv_jtag_dr_chain
  import nv_jtag_pkg::*;
#(
  parameter int                           NUM_SEG     = 4,
  parameter int                           SEG_WIDTH   = 16,
  parameter logic [NUM_SEG*SEG_WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                clk,
  input logic                reset_,
  nv_jtag_dr_chain_if.slave  dr
);

  localparam int CNT_W = cnt_width(NUM_SEG * SEG_WIDTH);

  tap_cmd_e           cmd;
  logic [NUM_SEG-1:0] en_q, en_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len;
  logic               err_q, err_d;
  logic               do_cap, do_shf, do_upd, upd_ok;
  logic [NUM_SEG:0]   chain;

  assign cmd    = tap_cmd(dr.sel, dr.captureDR, dr.shiftDR, dr.updateDR);
  assign len    = CNT_W'(chain_len({{(MAX_SEG-NUM_SEG){1'b0}}, en_q}, NUM_SEG, SEG_WIDTH));
  assign upd_ok = (cnt_q == len);

  always_comb begin
    en_d   = en_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    do_cap = 1'b0;
    do_shf = 1'b0;
    do_upd = 1'b0;
    unique case (cmd)
      CMD_CAP: begin
        do_cap = 1'b1;
        en_d   = dr.seg_en;
        cnt_d  = '0;
        err_d  = 1'b0;
      end
      CMD_SHF: begin
        do_shf = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
      CMD_UPD: begin
        do_upd = upd_ok;
        if (!upd_ok) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      en_q  <= '1;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      en_q  <= en_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // TDI feeds the top segment; each segment's output feeds the one below it.
  assign chain[NUM_SEG] = dr.scanin;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    nv_jtag_dr_seg #(
      .SEG_WIDTH   (SEG_WIDTH),
      .RESET_VALUE (RESET_VALUE[k*SEG_WIDTH +: SEG_WIDTH])
    ) u_seg (
      .clk    (clk),
      .reset_ (reset_),
      .en     (en_q[k]),
      .cap_en (dr.seg_en[k]),
      .cap    (do_cap),
      .shf    (do_shf),
      .upd    (do_upd),
      .d      (dr.D[k*SEG_WIDTH +: SEG_WIDTH]),
      .si     (chain[k+1]),
      .so     (chain[k]),
      .q      (dr.Q[k*SEG_WIDTH +: SEG_WIDTH])
    );
  end

  assign dr.scanout    = dr.sel ? chain[0] : 1'b0;
  assign dr.update_err = err_q;

endmodule

// File: tb/tb_nv_jtag_dr_chain.sv
// tb/tb_nv_jtag_dr_chain.sv - directed and randomized bench for nv_jtag_dr_chain
module tb_nv_jtag_dr_chain;

  localparam int NS = 4;
  localparam int SW = 8;
  localparam int NB = NS * SW;
  localparam int CNT_MAX = (1 << ($clog2(NB + 1) + 1)) - 1;
  localparam logic [NB-1:0] RV = 32'h5A5A_F00D;

  logic clk = 1'b0;
  logic reset_;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  nv_jtag_dr_chain_if #(.NUM_SEG(NS), .SEG_WIDTH(SW)) dr();

  nv_jtag_dr_chain #(.NUM_SEG(NS), .SEG_WIDTH(SW), .RESET_VALUE(RV)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .dr     (dr)
  );

  logic [NB-1:0] m_sh, m_q;
  logic [NS-1:0] m_byp, m_en;
  int            m_cnt;
  logic          m_err;

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_sh = '0; m_byp = '0; m_en = '1; m_cnt = 0; m_q = RV; m_err = 1'b0;
  endtask

  function automatic int m_len();
    int l = 0;
    for (int k = 0; k < NS; k++) l += m_en[k] ? SW : 1;
    return l;
  endfunction

  function automatic logic m_tdo();
    return m_en[0] ? m_sh[0] : m_byp[0];
  endfunction

  // Gather the active chain LSB-first, shift it as a list, scatter it back.
  task automatic m_shift(input logic si);
    logic q[$];
    int   idx;
    for (int k = 0; k < NS; k++) begin
      if (m_en[k]) for (int b = 0; b < SW; b++) q.push_back(m_sh[k*SW+b]);
      else q.push_back(m_byp[k]);
    end
    q.push_back(si);
    void'(q.pop_front());
    idx = 0;
    for (int k = 0; k < NS; k++) begin
      if (m_en[k]) for (int b = 0; b < SW; b++) begin m_sh[k*SW+b] = q[idx]; idx++; end
      else begin m_byp[k] = q[idx]; idx++; end
    end
  endtask

  task automatic step(input logic s, input logic c, input logic sh, input logic u, input logic si);
    dr.sel = s; dr.captureDR = c; dr.shiftDR = sh; dr.updateDR = u; dr.scanin = si;
    @(posedge clk); #1;
    if (s) begin
      if (c) begin
        m_en = dr.seg_en;
        for (int k = 0; k < NS; k++) if (m_en[k]) m_sh[k*SW +: SW] = dr.D[k*SW +: SW];
        m_byp = '0; m_cnt = 0; m_err = 1'b0;
      end else if (sh) begin
        m_shift(si);
        if (m_cnt < CNT_MAX) m_cnt++;
      end else if (u) begin
        if (m_cnt == m_len()) begin
          for (int k = 0; k < NS; k++) if (m_en[k]) m_q[k*SW +: SW] = m_sh[k*SW +: SW];
        end else m_err = 1'b1;
      end
    end
    check("scanout", 32'(dr.scanout), 32'(s ? m_tdo() : 1'b0));
    check("Q", dr.Q, m_q);
    check("update_err", 32'(dr.update_err), 32'(m_err));
  endtask

  task automatic capture(input logic [NS-1:0] en, input logic [NB-1:0] d);
    dr.seg_en = en; dr.D = d;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic shift_n(input logic [NB-1:0] data, input int n, output logic [NB-1:0] tdo);
    logic si;
    tdo = '0;
    for (int i = 0; i < n; i++) begin
      if (i < NB) tdo[i] = dr.scanout;
      si = (i < NB) ? data[i] : 1'($urandom);
      step(1'b1, 1'b0, 1'b1, 1'b0, si);
    end
  endtask

  task automatic update();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [NB-1:0] tdo, prev_q, rd, rv_v;
    logic [NS-1:0] en;
    int            l, n;

    rv_v = RV;
    reset_ = 1'b0;
    dr.sel = 1'b0; dr.captureDR = 1'b0; dr.shiftDR = 1'b0; dr.updateDR = 1'b0;
    dr.seg_en = '0; dr.D = '0; dr.scanin = 1'b0;
    m_reset();
    #12;
    check("reset_Q", dr.Q, RV);
    check("reset_scanout", 32'(dr.scanout), 32'd0);
    check("reset_err", 32'(dr.update_err), 32'd0);
    reset_ = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    update();
    check("upd_no_cap_err", 32'(dr.update_err), 32'd1);
    check("upd_no_cap_Q", dr.Q, RV);

    capture(4'hF, 32'hA5C3_0F81);
    shift_n(32'h1234_5678, 32, tdo);
    check("full_tdo", tdo, 32'hA5C3_0F81);
    update();
    check("full_Q", dr.Q, 32'h1234_5678);
    check("full_err", 32'(dr.update_err), 32'd0);

    prev_q = dr.Q;
    capture(4'b0101, $urandom);
    dr.seg_en = 4'hF;
    rd = $urandom;
    shift_n(rd, 18, tdo);
    check("bypass_seg1_bit", 32'(tdo[8]), 32'd0);
    update();
    check("bypass_seg1_hold", 32'(dr.Q[15:8]), 32'(prev_q[15:8]));
    check("bypass_seg3_hold", 32'(dr.Q[31:24]), 32'(prev_q[31:24]));
    check("bypass_seg0_new", 32'(dr.Q[7:0]), 32'(rd[7:0]));
    check("bypass_seg2_new", 32'(dr.Q[23:16]), 32'(rd[16:9]));

    prev_q = dr.Q;
    capture(4'hF, $urandom);
    shift_n($urandom, 31, tdo);
    update();
    check("len_err", 32'(dr.update_err), 32'd1);
    check("len_err_Q", dr.Q, prev_q);
    capture(4'hF, $urandom);
    check("cap_clears_err", 32'(dr.update_err), 32'd0);

    dr.seg_en = 4'hF; dr.D = $urandom;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    shift_n(32'hCAFE_0123, 10, tdo);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 10; i < 32; i++) step(1'b1, 1'b0, 1'b1, 1'b0, rd[i]);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("cap_beats_upd_err", 32'(dr.update_err), 32'd0);

    capture(4'hF, $urandom);
    shift_n($urandom, 10, tdo);
    reset_ = 1'b0;
    #2;
    m_reset();
    check("midreset_Q", dr.Q, rv_v);
    check("midreset_scanout", 32'(dr.scanout), 32'd0);
    check("midreset_err", 32'(dr.update_err), 32'd0);
    reset_ = 1'b1;
    capture(4'hF, $urandom);
    shift_n(32'h0BAD_F00D, 32, tdo);
    update();
    check("post_reset_Q", dr.Q, 32'h0BAD_F00D);

    for (int it = 0; it < 16; it++) begin
      en = 4'($urandom_range(0, 15));
      capture(en, $urandom);
      l = m_len();
      n = l - 1 + int'($urandom_range(0, 2));
      dr.seg_en = 4'($urandom_range(0, 15));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) step(1'b0, 1'b0, 1'b1, 1'b1, 1'($urandom));
        step(1'b1, 1'b0, 1'b1, 1'($urandom), 1'($urandom));
      end
      update();
      check("rand_err", 32'(dr.update_err), 32'(n != l));
    end

    prev_q = dr.Q;
    capture(4'hF, $urandom);
    shift_n($urandom, CNT_MAX + 10, tdo);
    update();
    check("sat_err", 32'(dr.update_err), 32'd1);
    check("sat_Q", dr.Q, prev_q);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
